// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD operand loader: FSM states, digit limit,
// and the digit-counter width helper.
package bcd_pkg;

  // Operand entry phases: entering X, entering Y, presenting both operands.
  typedef enum logic [1:0] {
    S_X   = 2'd0,
    S_Y   = 2'd1,
    S_OUT = 2'd2
  } state_t;

  // Largest legal decimal digit; anything above is rejected.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Width of a counter that must hold values 0..digits.
  function automatic int cnt_width(input int digits);
    return $clog2(digits + 1);
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// One packed-BCD operand register. Each enabled cycle shifts the operand
// left by one digit and inserts the new digit at bits [3:0].
module bcd_shift_reg #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [3:0]            digit_in,
  output logic [4*DIGITS-1:0]   q
);

  localparam int WIDTH = 4 * DIGITS;

  // Operand register: reset/clear empty it, otherwise shift in a digit.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst || clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= (q << 4) | WIDTH'(digit_in);
    end
  end

endmodule

// File: rtl/bcd_operand_loader.sv
// Registered front end for the multi-digit BCD adder. Collects digits MSD
// first into operands X then Y and presents them until acknowledged.
module bcd_operand_loader
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic             digit_ready,
  input  logic             op_done,
  output logic             digit_err,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             operands_valid,
  input  logic             operands_ack
);

  localparam int                CNT_W = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIGITS - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_digit_err;

  logic w_ready;
  logic w_accept;
  logic w_reject;
  logic w_complete;
  logic w_ack_take;
  logic w_clr_ops;
  logic w_shift_x;
  logic w_shift_y;

  // Handshake and completion decode shared by FSM, counter and operands.
  always_comb begin
    w_ready    = (r_state != S_OUT);
    w_accept   = w_ready && digit_valid && (digit_in <= BCD_MAX);
    w_reject   = w_ready && digit_valid && (digit_in >  BCD_MAX);
    w_complete = w_ready && (op_done || (w_accept && (r_cnt == LAST)));
    w_ack_take = (r_state == S_OUT) && operands_ack;
    w_clr_ops  = clear || w_ack_take;
    w_shift_x  = w_accept && (r_state == S_X);
    w_shift_y  = w_accept && (r_state == S_Y);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_X;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: clear aborts, completion advances, ack restarts.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_next_state = r_state;
    if (clear) begin
      w_next_state = S_X;
    end else begin
      case (r_state)
        S_X:     if (w_complete)   w_next_state = S_Y;
        S_Y:     if (w_complete)   w_next_state = S_OUT;
        S_OUT:   if (operands_ack) w_next_state = S_X;
        default:                   w_next_state = S_X;
      endcase
    end
  end

  // Output decode from state only.
  always_comb begin
    digit_ready    = (r_state != S_OUT);
    operands_valid = (r_state == S_OUT);
  end

  // Digit counter: restarts on completion, steps on each accepted digit.
  always_ff @(posedge clk) begin
    if (rst || w_clr_ops) begin
      r_cnt <= '0;
    end else if (w_complete) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Rejected-digit flag: one-cycle pulse after an out-of-range digit.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_digit_err <= 1'b0;
    end else begin
      r_digit_err <= w_reject;
    end
  end

  assign digit_err = r_digit_err;

  bcd_shift_reg #(.DIGITS(DIGITS)) u_x_reg (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr_ops),
    .shift_en (w_shift_x),
    .digit_in (digit_in),
    .q        (x)
  );

  bcd_shift_reg #(.DIGITS(DIGITS)) u_y_reg (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr_ops),
    .shift_en (w_shift_y),
    .digit_in (digit_in),
    .q        (y)
  );

endmodule

// File: doc/bcd_operand_loader.md
# bcd_operand_loader

Registered front end for the multi-digit BCD adder. It accepts decimal digits one per handshake, most significant digit first, and assembles them into two packed-BCD operands `x` and `y`. It then holds both operands stable with a valid flag until the consumer acknowledges them. Its `x`/`y` outputs connect directly to the adder's `x`/`y` inputs.

## Interface
Parameters:
- `DIGITS`, default 4: number of BCD digits per operand; must be ≥ 1.
- `WIDTH`, default 4*DIGITS: operand width in bits; derived, never overridden.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `clear` input 1: synchronous abort, returns the block to empty operand entry.
- `digit_in` input 4: digit offered by the upstream source.
- `digit_valid` input 1: `digit_in` is offered this cycle.
- `digit_ready` output 1: block can accept a digit this cycle.
- `op_done` input 1: ends the current operand early; missing leading digits are 0.
- `digit_err` output 1: one-cycle pulse when a rejected digit (>9) was offered.
- `x` output WIDTH: operand X, packed BCD, digit 0 in bits [3:0].
- `y` output WIDTH: operand Y, same format.
- `operands_valid` output 1: `x` and `y` are complete and stable.
- `operands_ack` input 1: consumer has taken the operands.

## Operation
- FSM has three states: `S_X` (entering X), `S_Y` (entering Y), `S_OUT` (presenting operands). Reset state is `S_X`.
- `digit_ready` = (state != `S_OUT`). It is decoded combinationally from state and does not depend on `digit_valid`.
- A digit is accepted when `digit_valid && digit_ready && digit_in <= 9`.
  - The active operand shifts left by 4 and `digit_in` enters bits [3:0].
  - The digit counter increments.
- Offered digit > 9 while ready: nothing is stored and the counter is unchanged. `digit_err` is 1 on the next cycle for exactly one cycle.
- Operand completion happens on an accepted digit when counter == DIGITS-1, or on `op_done` in `S_X`/`S_Y`. On completion the counter resets to 0 and the FSM moves `S_X`→`S_Y` or `S_Y`→`S_OUT`.
- Digit accepted in the same cycle as `op_done`: the digit is stored first, then the operand completes. This is one transition, not two.
- `op_done` with zero digits entered completes the operand with value 0.
- `S_OUT`: `operands_valid`=1, and `x`/`y` are frozen. `digit_valid` is ignored and produces no `digit_err`. `op_done` is ignored.
- `operands_ack` in `S_OUT`: next state is `S_X`, `x`=`y`=0, counter 0. `operands_ack` outside `S_OUT` is ignored.
- Priority: `rst` > `clear` > `operands_ack` > digit/`op_done` handling. `clear` has the same effect as `rst` on all state and outputs.

## Timing
- Reset values (`rst` or `clear`): state `S_X`, `x`=0, `y`=0, counter 0, `operands_valid`=0, `digit_err`=0, `digit_ready`=1.
- An accepted digit is visible on `x`/`y` one cycle after the accepting edge.
- `operands_valid` rises one cycle after the edge that completes Y, and falls one cycle after the `operands_ack` edge.
- Minimum throughput: 2*DIGITS digit cycles plus 1 ack cycle per operand pair. Back-to-back digits are accepted every cycle.
- `x`/`y` are registers with no combinational path from inputs, so they are safe to feed the combinational adder directly.
- `rst`/`clear` mid-entry discards partial operands with no output pulse.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum (`S_X`, `S_Y`, `S_OUT`);
  - the constant `BCD_MAX` = 4'd9;
  - the counter width function ($clog2(DIGITS+1)).
- Sub-module `bcd_shift_reg` (parameter `DIGITS`; ports `clk`, `rst`, `clr`, `shift_en`, `digit_in`, `q`) is instantiated twice, once for X and once for Y. The FSM and counter live in the top module.

## Test plan
- DIGITS=4: feed 1,2,3,4 then 5,6,7,8 back-to-back → `x`=16'h1234, `y`=16'h5678, `operands_valid` high the cycle after the 8th digit. Feed a further digit → not accepted.
- Feed 4, then `op_done`, then 9,9,9,9 → `x`=16'h0004, `y`=16'h9999. With an adder attached: `z`=16'h0003, `carry`=1.
- Feed 4'hB during X entry → no store, `digit_err` pulses one cycle, counter unchanged. Then 1,2,3,4 → `x`=16'h1234.
- Digit 7 with `op_done` in the same cycle as the first Y digit → `y`=16'h0007, `operands_valid` next cycle.
- In `S_OUT`, hold `operands_ack` low for 5 cycles → `x`/`y` stable, `digit_ready`=0. Pulse ack → `x`=`y`=0, `digit_ready`=1.
- `clear` after 3 digits of Y → all outputs at reset values next cycle. `rst` asserted with `operands_ack` → reset wins.
